// File: rtl/demux_pkg.sv
// Shared definitions for the stream demux dispatcher: default widths,
// FIFO depth and the channel identifier type.
package demux_pkg;

    localparam int DEF_DATA_W = 8;   // default payload width
    localparam int DEF_CNT_W  = 16;  // default per-channel beat counter width
    localparam int FIFO_DEPTH = 2;   // per-channel buffering, fixed

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

endpackage

// File: rtl/stream_demux_dispatch_fifo2.sv
// demux_fifo2: two-entry register FIFO used per output channel.
// The head entry is read straight from the storage array so that the
// payload stays constant while the consumer stalls. Push into a full FIFO
// and pop from an empty FIFO are ignored.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic              push_en;
    logic              pop_en;

    assign full     = (count_reg == 2'(DEPTH));
    assign empty    = (count_reg == 2'd0);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Storage and pointers; cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_en) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/stream_demux_dispatch.sv
// stream_demux_dispatch: registered 1:2 stream demultiplexer.
// Each accepted beat goes to a per-channel 2-entry FIFO; pops are counted
// per channel with wrap-around counters.
// Optional feature: define DEMUX_RR_EN to ignore in_sel and alternate the
// destination on every accepted beat (stalling if that channel is full).
module stream_demux_dispatch
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic [1:0] full_w;
    logic [1:0] empty_w;
    logic [1:0] push_w;
    logic [1:0] pop_w;
    logic [1:0] out_ready_w;
    chan_e      dest;
    logic       accept;

    assign out_ready_w = {out1_ready, out0_ready};

`ifdef DEMUX_RR_EN
    chan_e rr_ptr_reg;
    chan_e rr_ptr_next;
    logic  unused_in_sel;

    assign unused_in_sel = in_sel;
    assign dest          = rr_ptr_reg;

    // Round-robin pointer advances only when a beat is actually accepted.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            rr_ptr_next = (rr_ptr_reg == CH0) ? CH1 : CH0;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= CH0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    assign dest = in_sel ? CH1 : CH0;
`endif

    // Ready depends only on the chosen FIFO's fill state, never on the
    // downstream readies, so a pop on a full channel does not free a slot
    // in the same cycle.
    assign in_ready = ~full_w[dest];
    assign accept   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [DATA_W-1:0] head_w;
            logic [CNT_W-1:0]  cnt_reg;
            logic [CNT_W-1:0]  cnt_next;

            assign push_w[gi] = accept & (dest == ((gi == 0) ? CH0 : CH1));
            assign pop_w[gi]  = ~empty_w[gi] & out_ready_w[gi];

            demux_fifo2 #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push_w[gi]),
                .push_data (in_data),
                .pop       (pop_w[gi]),
                .pop_data  (head_w),
                .full      (full_w[gi]),
                .empty     (empty_w[gi])
            );

            // Beat counter steps on each delivered beat and wraps silently.
            always_comb begin
                cnt_next = cnt_reg;
                if (pop_w[gi]) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Beat counter register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign out0_data  = g_chan[0].head_w;
    assign out1_data  = g_chan[1].head_w;
    assign out0_valid = ~empty_w[0];
    assign out1_valid = ~empty_w[1];
    assign cnt0       = g_chan[0].cnt_reg;
    assign cnt1       = g_chan[1].cnt_reg;

endmodule

// File: tb/tb_stream_demux_dispatch.sv
// Testbench for stream_demux_dispatch: directed literal checks plus a
// queue-based reference model compared against the DUT on every falling edge.
module tb_stream_demux_dispatch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [7:0]  out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int n_vec;
    int n_err;

    // Reference model: per-channel queues, beat counts, round-robin pointer.
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [15:0] m_cnt0;
    logic [15:0] m_cnt1;
    logic        m_rr;

    stream_demux_dispatch #(
        .DATA_W (8),
        .CNT_W  (16),
        .DEPTH  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model compare and advance: check current outputs, then apply the
    // transfers the next rising edge will perform.
    always @(negedge clk) begin
        logic d;
        logic exp_ready;
        logic v0;
        logic v1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = '0;
            m_cnt1 = '0;
            m_rr   = 1'b0;
            check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
            check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
            check("rst_cnt0", {16'd0, cnt0}, 32'd0);
            check("rst_cnt1", {16'd0, cnt1}, 32'd0);
        end else begin
`ifdef DEMUX_RR_EN
            d = m_rr;
`else
            d = in_sel;
`endif
            exp_ready = d ? (q1.size() < 2) : (q0.size() < 2);
            v0 = (q0.size() != 0);
            v1 = (q1.size() != 0);
            check("mdl_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            check("mdl_out0_valid", {31'd0, out0_valid}, {31'd0, v0});
            check("mdl_out1_valid", {31'd0, out1_valid}, {31'd0, v1});
            if (v0) check("mdl_out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
            if (v1) check("mdl_out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
            check("mdl_cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
            check("mdl_cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
            if (v0 && out0_ready) begin
                void'(q0.pop_front());
                m_cnt0 = m_cnt0 + 16'd1;
            end
            if (v1 && out1_ready) begin
                void'(q1.pop_front());
                m_cnt1 = m_cnt1 + 16'd1;
            end
            if (in_valid && exp_ready) begin
                if (d) q1.push_back(in_data);
                else   q0.push_back(in_data);
                m_rr = ~m_rr;
            end
        end
    end

    task automatic randomize_inputs();
        in_valid   = ($urandom_range(0, 9) < 7);
        in_sel     = 1'($urandom_range(0, 1));
        in_data    = 8'($urandom);
        out0_ready = ($urandom_range(0, 9) < 6);
        out1_ready = ($urandom_range(0, 9) < 6);
    endtask

    initial begin
        int guard;
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) cyc();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out0_data", {24'd0, out0_data}, 32'd0);
        check("reset_out1_data", {24'd0, out1_data}, 32'd0);
        check("reset_cnt0", {16'd0, cnt0}, 32'd0);
        rst_n = 1'b1;
        cyc();

`ifdef DEMUX_RR_EN
        // Round-robin: in_sel fixed at 1, beats alternate ch0, ch1, ch0, ch1.
        in_sel = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11; cyc();
        in_data = 8'h22; cyc();
        in_data = 8'h33; cyc();
        in_data = 8'h44; cyc();
        in_valid = 1'b0;
        check("rr_out0_head", {24'd0, out0_data}, 32'h11);
        check("rr_out1_head", {24'd0, out1_data}, 32'h22);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        cyc();
        check("rr_out0_second", {24'd0, out0_data}, 32'h33);
        check("rr_out1_second", {24'd0, out1_data}, 32'h44);
        cyc();
        check("rr_cnt0", {16'd0, cnt0}, 32'd2);
        check("rr_cnt1", {16'd0, cnt1}, 32'd2);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
`else
        // Routing with both readies high.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
        cyc();
        check("route_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("route_out0_data", {24'd0, out0_data}, 32'hA5);
        in_sel = 1'b1; in_data = 8'h3C;
        cyc();
        check("route_out1_data", {24'd0, out1_data}, 32'h3C);
        check("route_cnt0", {16'd0, cnt0}, 32'd1);
        in_valid = 1'b0;
        cyc();
        check("route_cnt1", {16'd0, cnt1}, 32'd1);
        check("route_out1_drained", {31'd0, out1_valid}, 32'd0);

        // Backpressure on channel 0.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01;
        cyc();
        check("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
        in_data = 8'h02;
        cyc();
        check("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
        check("bp_head_held_a", {24'd0, out0_data}, 32'h01);
        in_data = 8'h03;
        cyc();
        check("bp_head_held_b", {24'd0, out0_data}, 32'h01);

        // Full channel with a concurrent pop: no same-cycle slot reuse.
        out0_ready = 1'b1;
        #1;
        check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        check("release_second", {24'd0, out0_data}, 32'h02);
        check("full_pop_ready_next", {31'd0, in_ready}, 32'd1);
        cyc();
        check("release_third", {24'd0, out0_data}, 32'h03);
        in_valid = 1'b0;
        cyc();
        check("release_empty", {31'd0, out0_valid}, 32'd0);
        check("release_cnt0", {16'd0, cnt0}, 32'd4);
        out0_ready = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            cyc();
        end

        // Stream channel 0 until its counter reaches all-ones, then one more.
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        guard = 0;
        while (m_cnt0 != 16'hFFFF && guard < 70000) begin
            in_data = 8'($urandom);
            cyc();
            guard++;
        end
        check("wrap_no_timeout", {31'd0, (guard < 70000)}, 32'd1);
        check("wrap_at_max", {16'd0, cnt0}, 32'h0000FFFF);
        check("wrap_valid_before", {31'd0, out0_valid}, 32'd1);
        cyc();
        check("wrap_to_zero", {16'd0, cnt0}, 32'd0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            in_valid = 1'b1;
            cyc();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("async_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("async_rst_cnt0", {16'd0, cnt0}, 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
